parallel_to_serial_shifter: RTL
===============================

// Module: parallel_to_serial_shifter
// PURPOSE
//   Transmit-side counterpart of the serial-in left shift register.
//   Accepts a SIZE-bit word over a valid/ready load handshake and emits it one bit per enabled clock.
//   Bit order is MSB first by default, so the capture-side left shifter reassembles the word unchanged.
//   Sits between a word source (register file or FIFO) and a bit-serial link.
// PARAMETERS
//   SIZE       8   word width in bits; legal range is SIZE >= 2
//   MSB_FIRST  1   1: shift left and emit bit SIZE-1 first; 0: shift right and emit bit 0 first
// PORTS
//   clk        in   1     single clock; all state updates on posedge
//   reset      in   1     synchronous, active-high reset
//   load_valid in   1     source offers load_data this cycle
//   load_data  in   SIZE  parallel word to transmit
//   load_ready out  1     shifter can accept a word this cycle
//   enable     in   1     advance one bit this cycle (link strobe)
//   data_out   out  1     current serial bit
//   data_valid out  1     data_out holds a word bit
//   last       out  1     data_out is the final bit of the word
//   busy       out  1     a word is in flight
//   done       out  1     one-cycle pulse after the final bit is consumed
// BEHAVIOUR
//   Reset (sampled on posedge clk while reset=1):
//     - state=IDLE; shift reg=0; bit counter=0; done=0.
//     - Outputs: load_ready=1 after reset deasserts; data_out=0, data_valid=0, last=0, busy=0.
//     - Reset mid-word drops the word: no done pulse, no further bits.
//   States:
//     - IDLE: load_ready=1; data_out=0, data_valid=0.
//       * load_valid=1 -> capture load_data, cnt=SIZE-1, go to SHIFT.
//       * enable is ignored in IDLE.
//     - SHIFT: busy=1, data_valid=1, last=(cnt==0).
//       * data_out = sreg[SIZE-1] (MSB_FIRST=1) or sreg[0] (MSB_FIRST=0).
//       * enable=1 -> shift by one, fill vacated bit with 0, cnt=cnt-1.
//       * enable=0 -> hold sreg, cnt and data_out.
//   Word end (SHIFT, cnt==0, enable=1):
//     - done=1 on the next cycle only.
//     - State returns to IDLE unless a back-to-back load occurs.
//   Back-to-back load:
//     - load_ready = (state==IDLE) | (state==SHIFT & cnt==0 & enable); combinational.
//     - Load accepted at word end -> capture the new word, cnt=SIZE-1, stay in SHIFT.
//     - First bit of the new word appears the next cycle with no idle gap; done still pulses.
//   Handshake rules:
//     - Load occurs only when load_valid & load_ready.
//     - load_valid while not ready is ignored; the source must hold the word until accepted.
//   Latency and width:
//     - Load -> first bit valid: 1 cycle.
//     - A word occupies exactly SIZE enabled cycles.
//     - cnt width is $clog2(SIZE); no wrap, because cnt reloads at 0.
//   Simultaneous events: reset overrides load and enable.
// STRUCTURE
//   - Shared header shift_defs.vh: state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1.
//   - One sub-module is natural: bit_down_counter.
//     * Parameter WIDTH.
//     * Ports: load, load_value, decrement, count, zero.
//   - Shift register, FSM and output decode stay in this module.
// TESTING
//   1. Single word, SIZE=8:
//      - load 8'hA5, enable held 1 -> data_out 1,0,1,0,0,1,0,1 on consecutive cycles.
//      - last=1 only on the 8th bit; done=1 one cycle later.
//   2. Stalls:
//      - load 8'hC3, enable toggled 1,0,0,1,...
//      - Each bit held while enable=0; 8 enabled cycles total; captured word 8'hC3 on a SIPO receiver.
//   3. Back-to-back:
//      - load 8'hFF, then hold load_valid=1 with 8'h00.
//      - Second load accepted on the last-bit cycle; 16 consecutive bits 8x1 then 8x0.
//      - done pulses twice; busy never drops.
//   4. Reset mid-word:
//      - load 8'h5A, reset after 3 enabled bits.
//      - Next cycle: data_valid=0, busy=0, data_out=0, done=0, load_ready=1.
//   5. LSB first, MSB_FIRST=0:
//      - load 8'h01 -> data_out 1 then seven 0s.
//   6. Ignored inputs:
//      - enable=1 in IDLE -> no state change.
//      - load_valid mid-word (cnt!=0) -> word unchanged, load_ready=0.

Source files
------------

// File: rtl/parallel_to_serial_shifter_pkg.sv
// ---------------------------------------------------------------------------
// parallel_to_serial_shifter_pkg
//   Shared definitions for the parallel-to-serial shifter slice: the FSM
//   state encoding, the default word width and a helper that sizes the
//   bit counter.
// ---------------------------------------------------------------------------
package parallel_to_serial_shifter_pkg;

   localparam int DEFAULT_SIZE = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // The counter only has to hold SIZE-1 down to 0, so $clog2(SIZE) bits
   // are enough; the floor of 1 keeps the vector legal for tiny words.
   function automatic int cnt_width(input int size);
      return (size < 2) ? 1 : $clog2(size);
   endfunction

endpackage

// File: rtl/parallel_to_serial_shifter_if.sv
// ---------------------------------------------------------------------------
// parallel_to_serial_shifter_if
//   Bundles the load handshake and the serial link outputs of the shifter.
//   master : word source / link consumer (drives load_valid, load_data,
//            enable; observes everything else)
//   slave  : the shifter itself
//   Signals:
//     load_valid  source offers load_data this cycle
//     load_data   SIZE-bit parallel word
//     load_ready  shifter can accept a word this cycle
//     enable      link strobe, advance one bit
//     data_out    current serial bit
//     data_valid  data_out holds a word bit
//     last        data_out is the final bit of the word
//     busy        a word is in flight
//     done        one-cycle pulse after the final bit is consumed
// ---------------------------------------------------------------------------
interface parallel_to_serial_shifter_if #(
   parameter int SIZE = 8
);
   logic            load_valid;
   logic [SIZE-1:0] load_data;
   logic            load_ready;
   logic            enable;
   logic            data_out;
   logic            data_valid;
   logic            last;
   logic            busy;
   logic            done;

   modport master (
      output load_valid,
      output load_data,
      output enable,
      input  load_ready,
      input  data_out,
      input  data_valid,
      input  last,
      input  busy,
      input  done
   );

   modport slave (
      input  load_valid,
      input  load_data,
      input  enable,
      output load_ready,
      output data_out,
      output data_valid,
      output last,
      output busy,
      output done
   );
endinterface

// File: rtl/parallel_to_serial_shifter_bit_down_counter.sv
// ---------------------------------------------------------------------------
// bit_down_counter
//   Loadable down counter that tracks how many bits of the current word are
//   still to go after the one on the wire.
//   Ports:
//     clk, reset  clock and synchronous active-high reset (count -> 0)
//     load        take load_value on the next edge (wins over decrement)
//     load_value  reload value
//     decrement   count down by one on the next edge
//     count       current count
//     zero        count is zero
// ---------------------------------------------------------------------------
module bit_down_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             decrement,
   output logic [WIDTH-1:0] count,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // A reload takes priority so a back-to-back word restarts cleanly even
   // though the final bit of the previous word is being consumed.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (decrement) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/parallel_to_serial_shifter.sv
// ---------------------------------------------------------------------------
// parallel_to_serial_shifter
//   Takes a SIZE-bit word over a valid/ready handshake and emits it one bit
//   per enabled clock, MSB first by default so a left-shifting capture
//   register rebuilds the word unchanged. A new word can be accepted on the
//   cycle the final bit is consumed, giving gap-free back-to-back words.
//   Parameters:
//     SIZE       word width (>= 2)
//     MSB_FIRST  1: shift left, emit bit SIZE-1 first; 0: shift right,
//                emit bit 0 first
//   Ports:
//     clk    single clock, all state on posedge
//     reset  synchronous active-high reset, drops any word in flight
//     bus    slave side of parallel_to_serial_shifter_if
// ---------------------------------------------------------------------------
module parallel_to_serial_shifter
   import parallel_to_serial_shifter_pkg::*;
#(
   parameter int SIZE      = DEFAULT_SIZE,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                           clk,
   input  logic                           reset,
   parallel_to_serial_shifter_if.slave    bus
);

   localparam int CNT_W = cnt_width(SIZE);

   state_t            state_q;
   state_t            state_d;
   logic [SIZE-1:0]   sreg_q;
   logic [SIZE-1:0]   sreg_d;
   logic              done_q;
   logic              done_d;

   logic [CNT_W-1:0]  cnt_count;
   logic              cnt_zero;
   logic              in_shift;
   logic              word_end;
   logic              load_ready;
   logic              load_fire;
   logic              cnt_decrement;
   logic [SIZE-1:0]   sreg_shifted;

   // Decode of the handshake. The final enabled bit of a word frees the
   // shifter in the same cycle, which is what lets a waiting source load
   // without an idle gap on the link.
   always_comb begin
      in_shift      = (state_q == ST_SHIFT);
      word_end      = in_shift && cnt_zero && bus.enable;
      load_ready    = (state_q == ST_IDLE) || word_end;
      load_fire     = bus.load_valid && load_ready;
      cnt_decrement = in_shift && bus.enable && (cnt_count != '0);
   end

   // Shift by one with a zero fill; direction follows the bit order so the
   // bit on the wire is always the one at the output end of the register.
   always_comb begin
      sreg_shifted = '0;
      if (MSB_FIRST) begin
         sreg_shifted = {sreg_q[SIZE-2:0], 1'b0};
      end else begin
         sreg_shifted = {1'b0, sreg_q[SIZE-1:1]};
      end
   end

   // Next-state logic. In IDLE the link strobe is ignored; in SHIFT the
   // register only moves on enable, and a word end either reloads (back to
   // back) or falls back to IDLE. done is raised for the cycle after the
   // final bit is taken.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      done_d  = word_end;
      case (state_q)
         ST_IDLE: begin
            if (bus.load_valid) begin
               sreg_d  = bus.load_data;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (word_end) begin
               if (bus.load_valid) begin
                  sreg_d = bus.load_data;
               end else begin
                  sreg_d  = sreg_shifted;
                  state_d = ST_IDLE;
               end
            end else if (bus.enable) begin
               sreg_d = sreg_shifted;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, shift register and done pulse; reset overrides load and enable
   // and drops any word in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sreg_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         done_q  <= done_d;
      end
   end

   // Bits remaining after the current one; reloads to SIZE-1 on every
   // accepted word so it never has to wrap.
   bit_down_counter #(
      .WIDTH (CNT_W)
   ) u_bit_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (load_fire),
      .load_value (CNT_W'(SIZE - 1)),
      .decrement  (cnt_decrement),
      .count      (cnt_count),
      .zero       (cnt_zero)
   );

   // Output decode; data_out is forced low outside a word so the link
   // idles at 0.
   always_comb begin
      bus.load_ready = load_ready;
      bus.busy       = in_shift;
      bus.data_valid = in_shift;
      bus.last       = in_shift && cnt_zero;
      bus.done       = done_q;
      bus.data_out   = 1'b0;
      if (in_shift) begin
         bus.data_out = MSB_FIRST ? sreg_q[SIZE-1] : sreg_q[0];
      end
   end

endmodule
